clk_mon_sel: RTL and testbench
==============================

# clk_mon_sel

Clock-source supervisor that generates the `select` input of the two-input clock multiplexer. It runs on the always-present reference clock. It counts edges of the alternate clock over fixed windows and switches `select` to the alternate clock only after that clock has stayed in range for several windows. It falls back to the reference clock as soon as the alternate clock goes out of range or stalls.

## Interface
Parameters:
- `WINDOW`, 256: measurement window length in `clk` cycles; must be a power of two, at least 16.
- `CNT_W`, 8: edge counter width; counter saturates at 2^CNT_W-1.
- `MIN_EDGES`, 16: minimum edges per window for the window to count as good.
- `MAX_EDGES`, 112: maximum edges per window for the window to count as good; must be less than WINDOW/2.
- `GOOD_WINDOWS`, 3: consecutive good windows required before switching to the alternate clock.
- `STALL_CYC`, 32: number of edge-free `clk` cycles that forces fallback while on the alternate clock.

Ports:
- `clk`, input, 1: reference clock; the single clock domain of the block.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `clk_mon`, input, 1: alternate clock being monitored; asynchronous to `clk`.
- `force_ref`, input, 1: when 1, holds `select` at 0 (reference clock).
- `select`, output, 1: drives the mux; 0 selects the reference clock, 1 selects the alternate clock; registered.
- `edge_count`, output, CNT_W: edge count of the last completed window.
- `count_valid`, output, 1: one-cycle pulse when `edge_count` updates.
- `mon_ok`, output, 1: 1 when the last completed window was good.

## Operation
- **Synchronizer:** `clk_mon` passes through two flops, then a third flop for rising-edge detection. `edge_now` = sync2 & ~sync3. An edge on the pin shows up as `edge_now` 3 cycles later.
- **Window counter:** `w` counts from 0 to WINDOW-1 and wraps. It runs freely from reset, independent of FSM state and `force_ref`.
- **Edge counter:** `acc` adds `edge_now` every cycle and saturates.
- **Window close:** on the cycle where w==WINDOW-1:
  - `edge_count` <= sat(acc + edge_now).
  - `count_valid` <= 1.
  - `acc` <= 0.
  - good = MIN_EDGES <= that value <= MAX_EDGES.
  - `mon_ok` <= good.
- **FSM** (evaluated on the window-close cycle unless stated otherwise):
  - **REF** (`select`=0): on a good window, go to QUAL with `gcnt`=1. If GOOD_WINDOWS==1, go straight to ALT instead.
  - **QUAL** (`select`=0): on a good window, `gcnt`++; when `gcnt` reaches GOOD_WINDOWS, go to ALT. On a bad window, go to REF and clear `gcnt`.
  - **ALT** (`select`=1): on a bad window, go to REF. This state also has an independent stall watchdog:
    - `stall` resets to 0 on `edge_now` and otherwise increments every cycle.
    - When `stall` reaches STALL_CYC-1 with no edge, go to REF on that edge of `clk`, mid-window if necessary.
- **`force_ref`=1:** state goes to REF and `gcnt` is cleared on the next edge, overriding everything else. Measurement continues. `force_ref` is level-sensitive; qualification restarts from the first window that closes after it drops.
- **Priority:** reset > `force_ref` > stall > window verdict.

## Timing
- **Reset values:** `select`=0, `edge_count`=0, `count_valid`=0, `mon_ok`=0, state=REF, `w`=0, `acc`=0, `gcnt`=0, `stall`=0, synchronizer flops=0.
- **Window close:** `select`, `edge_count`, `count_valid` and `mon_ok` all change on the same edge of `clk` (the one closing the window).
- **Switch-in:** the earliest switch to the alternate clock happens at the close of the GOOD_WINDOWS-th good window. With defaults and `clk_mon` present from reset, that is after 3×256 cycles.
- **Stall fallback:** latency is no more than STALL_CYC+3 cycles from the last `clk_mon` pin edge.
- **`force_ref` latency:** 1 cycle to `select`=0.
- **Mid-operation reset:** outputs take their reset values asynchronously, and the first window after reset release is a full WINDOW cycles long.
- **Saturation:** `acc` holds at all ones. A saturated count is bad whenever MAX_EDGES < 2^CNT_W-1.

## Structure
- **Shared package/include `clk_mon_pkg`:** state encoding (REF=2'd0, QUAL=2'd1, ALT=2'd2) and the `select` encoding constants (SEL_REF=0, SEL_ALT=1), also used by the mux wrapper.
- **Sub-module `sync_edge`:** 2-flop synchronizer plus rising-edge detector, asynchronous active-low reset.
- **Top level:** window counter, accumulator, verdict, FSM and stall counter.

## Test plan
- `clk_mon` = `clk`/8 from reset, defaults → each `count_valid` reports 32±1, `mon_ok`=1; `select` rises at the edge of the 3rd `count_valid` (about cycle 768), not earlier.
- While in ALT, hold `clk_mon` at 0 → `select`=0 no more than 35 cycles after the last pin edge, mid-window; `edge_count` at the next close is below 16.
- `clk_mon` = `clk`/2 → counts of 127–128 > 112, `mon_ok`=0, `select` stays 0 indefinitely; change to `clk`/20 (about 12.8 edges, bad) → still 0.
- Two good windows, then one window with `clk_mon` stopped → FSM returns to REF; three further good windows needed before `select`=1.
- In ALT, pulse `force_ref` for 10 cycles → `select`=0 one cycle after it rises; `select`=1 again only at the 3rd good window closing after it falls.
- Assert `rst_n`=0 in QUAL and again in ALT mid-window → all outputs 0 immediately; after release, `count_valid` is first seen exactly 256 cycles later.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Encodings shared by the clock-source supervisor and the clock mux wrapper.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_REF  = 2'd0,
    ST_QUAL = 2'd1,
    ST_ALT  = 2'd2
  } mon_state_e;

  localparam logic SEL_REF = 1'b0;
  localparam logic SEL_ALT = 1'b1;

  function automatic logic in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/clk_mon_sel_sync_edge.sv
// Two-flop synchronizer for an asynchronous clock pin plus rising-edge detect.
// A pin edge appears as a one-cycle edge_now pulse about three clk edges later.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic edge_now
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign edge_now = s2_q & ~s3_q;

endmodule

// File: rtl/clk_mon_sel.sv
// Clock-source supervisor: measures clk_mon edges per window and drives the mux select.
// Switches in after GOOD_WINDOWS good windows; falls back on a bad window, stall or force_ref.
module clk_mon_sel
  import clk_mon_pkg::*;
#(
  parameter int WINDOW       = 256,
  parameter int CNT_W        = 8,
  parameter int MIN_EDGES    = 16,
  parameter int MAX_EDGES    = 112,
  parameter int GOOD_WINDOWS = 3,
  parameter int STALL_CYC    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_mon,
  input  logic             force_ref,
  output logic             select,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic             mon_ok
);

  localparam int WW = $clog2(WINDOW);
  localparam int GW = $clog2(GOOD_WINDOWS + 1);
  localparam int SW = $clog2(STALL_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             edge_now;
  logic [WW-1:0]    w_q, w_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] edge_count_q, edge_count_d;
  logic             count_valid_q, count_valid_d;
  logic             mon_ok_q, mon_ok_d;
  mon_state_e       state_q, state_d;
  logic [GW-1:0]    gcnt_q, gcnt_d, gcnt_inc;
  logic [SW-1:0]    stall_q, stall_d;
  logic             select_q, select_d;
  logic [CNT_W-1:0] acc_sum;
  logic             win_close, win_good, stall_hit;

  sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (clk_mon),
    .edge_now (edge_now)
  );

  always_comb begin
    win_close = (w_q == WW'(WINDOW - 1));
    acc_sum   = (acc_q == CNT_MAX) ? acc_q : acc_q + CNT_W'(edge_now);
    win_good  = in_range(int'(acc_sum), MIN_EDGES, MAX_EDGES);
    stall_hit = (state_q == ST_ALT) && !edge_now && (stall_q == SW'(STALL_CYC - 1));
    gcnt_inc  = gcnt_q + 1'b1;

    w_d           = w_q + 1'b1;
    acc_d         = win_close ? '0 : acc_sum;
    edge_count_d  = win_close ? acc_sum : edge_count_q;
    count_valid_d = win_close;
    mon_ok_d      = win_close ? win_good : mon_ok_q;

    // Stall holds at its threshold so a long gap outside ALT still trips on entry.
    if (edge_now)                           stall_d = '0;
    else if (stall_q == SW'(STALL_CYC - 1)) stall_d = stall_q;
    else                                    stall_d = stall_q + 1'b1;

    state_d = state_q;
    gcnt_d  = gcnt_q;
    if (force_ref || stall_hit) begin
      state_d = ST_REF;
      gcnt_d  = '0;
    end else if (win_close) begin
      case (state_q)
        ST_REF: begin
          if (win_good) begin
            if (GOOD_WINDOWS == 1) state_d = ST_ALT;
            else                   state_d = ST_QUAL;
            gcnt_d = GW'(1);
          end
        end
        ST_QUAL: begin
          if (win_good) begin
            gcnt_d = gcnt_inc;
            if (gcnt_inc >= GW'(GOOD_WINDOWS)) state_d = ST_ALT;
          end else begin
            state_d = ST_REF;
            gcnt_d  = '0;
          end
        end
        ST_ALT: begin
          if (!win_good) begin
            state_d = ST_REF;
            gcnt_d  = '0;
          end
        end
        default: begin
          state_d = ST_REF;
          gcnt_d  = '0;
        end
      endcase
    end

    select_d = (state_d == ST_ALT) ? SEL_ALT : SEL_REF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q           <= '0;
      acc_q         <= '0;
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
      mon_ok_q      <= 1'b0;
      state_q       <= ST_REF;
      gcnt_q        <= '0;
      stall_q       <= '0;
      select_q      <= SEL_REF;
    end else begin
      w_q           <= w_d;
      acc_q         <= acc_d;
      edge_count_q  <= edge_count_d;
      count_valid_q <= count_valid_d;
      mon_ok_q      <= mon_ok_d;
      state_q       <= state_d;
      gcnt_q        <= gcnt_d;
      stall_q       <= stall_d;
      select_q      <= select_d;
    end
  end

  assign select      = select_q;
  assign edge_count  = edge_count_q;
  assign count_valid = count_valid_q;
  assign mon_ok      = mon_ok_q;

endmodule

// File: tb/tb_clk_mon_sel.sv
// Randomized bench for clk_mon_sel with a window/streak/timestamp reference model.
module tb_clk_mon_sel;

  localparam int WINDOW = 256;
  localparam int MIN_E  = 16;
  localparam int MAX_E  = 112;
  localparam int GOOD   = 3;
  localparam int STALL  = 32;
  localparam int CMAX   = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clk_mon = 1'b0;
  logic       force_ref = 1'b0;
  logic       select, count_valid, mon_ok;
  logic [7:0] edge_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mon_per = 0;
  int last_rise = 0;
  bit chk_en = 1'b0;

  // reference model state
  int m_n = 0, m_cnt = 0, m_last_en = 0, m_streak = 0, m_ec = 0;
  bit m_h1 = 0, m_h2 = 0, m_h3 = 0, m_alt = 0, m_cv = 0, m_ok = 0;

  clk_mon_sel dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_mon     (clk_mon),
    .force_ref   (force_ref),
    .select      (select),
    .edge_count  (edge_count),
    .count_valid (count_valid),
    .mon_ok      (mon_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d..%0d", nm, cyc, act, lo, hi);
    end
  endtask

  task automatic wait_cv(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!count_valid && n < 400);
    chk({nm, "_cv_seen"}, int'(count_valid), 1);
  endtask

  task automatic do_reset(input string nm);
    int n;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk({nm, "_rst_select"}, int'(select), 0);
    chk({nm, "_rst_ec"}, int'(edge_count), 0);
    chk({nm, "_rst_cv"}, int'(count_valid), 0);
    chk({nm, "_rst_ok"}, int'(mon_ok), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!count_valid && n < 400);
    chk({nm, "_first_cv_delay"}, n, WINDOW);
  endtask

  // Clock-pin generator: period in clk cycles, 0 holds the pin low.
  initial begin
    int ph;
    bit nv;
    ph = 0;
    forever begin
      @(negedge clk);
      #1;
      if (mon_per == 0) begin
        clk_mon = 1'b0;
      end else begin
        ph = (ph + 1) % mon_per;
        nv = (ph < mon_per / 2);
        if (nv && !clk_mon) last_rise = cyc;
        clk_mon = nv;
      end
    end
  end

  // Reference model: edges reach the counter two samples late; windows close every
  // WINDOW cycles after reset; select follows a streak of good windows.
  initial begin
    bit en, close, good;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_n = 0; m_cnt = 0; m_last_en = 0; m_streak = 0; m_ec = 0;
        m_h1 = 0; m_h2 = 0; m_h3 = 0; m_alt = 0; m_cv = 0; m_ok = 0;
      end else begin
        m_n++;
        en = m_h2 && !m_h3;
        m_h3 = m_h2; m_h2 = m_h1; m_h1 = clk_mon;
        if (en) m_last_en = m_n;
        m_cnt = (m_cnt + int'(en) > CMAX) ? CMAX : m_cnt + int'(en);
        close = (m_n % WINDOW) == 0;
        good = 1'b0;
        m_cv = 1'b0;
        if (close) begin
          m_ec = m_cnt;
          m_cv = 1'b1;
          good = (m_cnt >= MIN_E) && (m_cnt <= MAX_E);
          m_ok = good;
          m_cnt = 0;
        end
        if (force_ref) begin
          m_alt = 0; m_streak = 0;
        end else if (m_alt && !en && (m_n - m_last_en) >= STALL) begin
          m_alt = 0; m_streak = 0;
        end else if (close) begin
          if (good) begin
            m_streak++;
            if (m_streak >= GOOD) m_alt = 1;
          end else begin
            m_alt = 0; m_streak = 0;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("model_select", int'(select), int'(m_alt));
        chk("model_edge_count", int'(edge_count), m_ec);
        chk("model_count_valid", int'(count_valid), int'(m_cv));
        chk("model_mon_ok", int'(mon_ok), int'(m_ok));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int rel, n, dur, fcnt;
    int per_tab[12];
    per_tab = '{0, 2, 4, 6, 8, 8, 8, 10, 14, 16, 20, 24};
    fcnt = 0;

    #1 rst_n = 1'b0;
    #1;
    chk_en = 1'b1;
    chk("init_select", int'(select), 0);
    chk("init_edge_count", int'(edge_count), 0);
    chk("init_count_valid", int'(count_valid), 0);
    chk("init_mon_ok", int'(mon_ok), 0);
    mon_per = 8;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;

    // clk/8 from reset: switch-in exactly at the third window close
    for (int i = 1; i <= 3; i++) begin
      wait_cv("div8");
      chk("div8_close_cycle", cyc - rel, i * WINDOW);
      chk_rng("div8_edge_count", int'(edge_count), 31, 33);
      chk("div8_mon_ok", int'(mon_ok), 1);
      chk("div8_select", int'(select), (i == 3) ? 1 : 0);
    end

    // stall while on the alternate clock
    repeat (60) @(negedge clk);
    #1 mon_per = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (select && n < 100);
    chk("stall_select", int'(select), 0);
    chk_rng("stall_latency", cyc - last_rise, STALL, STALL + 3);
    chk("stall_midwindow", int'(count_valid), 0);
    wait_cv("stall");
    chk_rng("stall_edge_count", int'(edge_count), 0, MIN_E - 1);
    chk("stall_mon_ok", int'(mon_ok), 0);

    // too fast, then too slow: never selected
    #1 mon_per = 2;
    for (int i = 0; i < 3; i++) begin
      wait_cv("div2");
      chk_rng("div2_edge_count", int'(edge_count), MAX_E + 1, CMAX);
      chk("div2_mon_ok", int'(mon_ok), 0);
      chk("div2_select", int'(select), 0);
    end
    #1 mon_per = 20;
    for (int i = 0; i < 3; i++) begin
      wait_cv("div20");
      chk_rng("div20_edge_count", int'(edge_count), 0, MIN_E - 1);
      chk("div20_select", int'(select), 0);
    end

    // two good windows, one stopped, then three more good ones are needed
    #1 mon_per = 8;
    for (int i = 0; i < 6; i++) begin
      wait_cv("requal");
      chk("requal_mon_ok", int'(mon_ok), (i == 2) ? 0 : 1);
      chk("requal_select", int'(select), (i == 5) ? 1 : 0);
      if (i == 1) #1 mon_per = 0;
      if (i == 2) #1 mon_per = 8;
    end

    // force_ref pulse in ALT
    repeat (50) @(negedge clk);
    #1 force_ref = 1'b1;
    @(negedge clk);
    chk("force_latency_select", int'(select), 0);
    repeat (9) @(negedge clk);
    #1 force_ref = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wait_cv("force_requal");
      chk("force_requal_mon_ok", int'(mon_ok), 1);
      chk("force_requal_select", int'(select), (i == 3) ? 1 : 0);
    end

    // asynchronous reset mid-window in ALT, then in QUAL
    repeat (80) @(negedge clk);
    do_reset("rst_alt");
    chk("rst_alt_select_after", int'(select), 0);
    repeat (100) @(negedge clk);
    do_reset("rst_qual");

    // randomized traffic with occasional force pulses and resets
    for (int s = 0; s < 30; s++) begin
      @(negedge clk);
      #1 mon_per = per_tab[$urandom_range(0, 11)];
      dur = $urandom_range(40, 1500);
      for (int c = 0; c < dur; c++) begin
        @(negedge clk);
        #1;
        if (fcnt > 0) begin
          fcnt--;
          if (fcnt == 0) force_ref = 1'b0;
        end else if ($urandom_range(0, 399) == 0) begin
          force_ref = 1'b1;
          fcnt = $urandom_range(1, 30);
        end
        if ($urandom_range(0, 2999) == 0) begin
          rst_n = 1'b0;
          #1 rst_n = 1'b1;
        end
      end
    end
    force_ref = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
